mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Shared-SRAM arbiter bus: fetch, data and loader request ports plus the SRAM command port.
// The arbiter connects through the slave modport; the requesters and SRAM through master.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic              im_gnt;
    logic              im_rvalid;
    logic [31:0]       im_rdata;

    logic              dm_req;
    logic [3:0]        dm_w_en;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [31:0]       dm_rdata;

    logic              ld_lock;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_gnt;

    logic              stall;

    logic [3:0]        sram_w_en;
    logic [ADDR_W-1:0] sram_address;
    logic [31:0]       sram_write_data;
    logic [31:0]       sram_read_data;

    modport slave (
        input  im_req, im_addr, dm_req, dm_w_en, dm_addr, dm_wdata,
        input  ld_lock, ld_req, ld_addr, ld_wdata, sram_read_data,
        output im_gnt, im_rvalid, im_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output ld_gnt, stall, sram_w_en, sram_address, sram_write_data
    );

    modport master (
        output im_req, im_addr, dm_req, dm_w_en, dm_addr, dm_wdata,
        output ld_lock, ld_req, ld_addr, ld_wdata, sram_read_data,
        input  im_gnt, im_rvalid, im_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  ld_gnt, stall, sram_w_en, sram_address, sram_write_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter: data beats fetch unless fetch has starved, boot loader
// gets exclusive write access while locked. Read data returns one cycle after grant.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic        clk,
    input logic        rst,
    mem_arbiter_if.slave bus
);
    localparam logic       ST_NORMAL = 1'b0;
    localparam logic       ST_LOCKED = 1'b1;
    localparam logic [1:0] TAG_NONE  = 2'd0;
    localparam logic [1:0] TAG_IM    = 2'd1;
    localparam logic [1:0] TAG_DM    = 2'd2;
    localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

    logic        r_state;
    logic        w_state_d;
    logic [3:0]  r_starve;
    logic [3:0]  w_starve_d;
    logic [1:0]  r_tag;
    logic [1:0]  w_tag_d;
    logic [31:0] r_im_rdata;
    logic [31:0] r_dm_rdata;

    logic              w_normal;
    logic              w_locked;
    logic              w_im_prio;
    logic              w_im_gnt;
    logic              w_dm_gnt;
    logic              w_ld_gnt;
    logic              w_im_rvalid;
    logic              w_dm_rvalid;
    logic [3:0]        w_sram_w_en;
    logic [ADDR_W-1:0] w_sram_addr;
    logic [31:0]       w_sram_wdata;

    // Reset gates every grant and strobe so nothing escapes while rst is held.
    assign w_normal  = ~rst & (r_state == ST_NORMAL);
    assign w_locked  = ~rst & (r_state == ST_LOCKED);
    assign w_im_prio = (r_starve == LIMIT);

    assign w_im_gnt = w_normal & bus.im_req & (w_im_prio | ~bus.dm_req);
    assign w_dm_gnt = w_normal & bus.dm_req & ~(w_im_prio & bus.im_req);
    assign w_ld_gnt = w_locked & bus.ld_req;

    assign w_im_rvalid = ~rst & (r_tag == TAG_IM);
    assign w_dm_rvalid = ~rst & (r_tag == TAG_DM);

    always_comb begin
        w_sram_w_en  = 4'b0000;
        w_sram_addr  = '0;
        w_sram_wdata = '0;
        if (w_ld_gnt) begin
            w_sram_w_en  = 4'b1111;
            w_sram_addr  = bus.ld_addr;
            w_sram_wdata = bus.ld_wdata;
        end else if (w_dm_gnt) begin
            w_sram_w_en  = bus.dm_w_en;
            w_sram_addr  = bus.dm_addr;
            w_sram_wdata = bus.dm_wdata;
        end else if (w_im_gnt) begin
            w_sram_addr  = bus.im_addr;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (r_state == ST_NORMAL) begin
            if (bus.ld_lock) w_state_d = ST_LOCKED;
        end else if (!bus.ld_lock && r_tag == TAG_NONE) begin
            w_state_d = ST_NORMAL;
        end

        w_starve_d = 4'd0;
        if (bus.im_req && !w_im_gnt) begin
            w_starve_d = (r_starve >= LIMIT) ? LIMIT : r_starve + 4'd1;
        end

        w_tag_d = TAG_NONE;
        if (w_im_gnt) begin
            w_tag_d = TAG_IM;
        end else if (w_dm_gnt && bus.dm_w_en == 4'b0000) begin
            w_tag_d = TAG_DM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_NORMAL;
            r_starve   <= 4'd0;
            r_tag      <= TAG_NONE;
            r_im_rdata <= 32'h0;
            r_dm_rdata <= 32'h0;
        end else begin
            r_state  <= w_state_d;
            r_starve <= w_starve_d;
            r_tag    <= w_tag_d;
            if (w_im_rvalid) r_im_rdata <= bus.sram_read_data;
            if (w_dm_rvalid) r_dm_rdata <= bus.sram_read_data;
        end
    end

    // Pass SRAM data straight through on the valid cycle, hold the last word otherwise.
    assign bus.im_rdata  = w_im_rvalid ? bus.sram_read_data : r_im_rdata;
    assign bus.dm_rdata  = w_dm_rvalid ? bus.sram_read_data : r_dm_rdata;
    assign bus.im_rvalid = w_im_rvalid;
    assign bus.dm_rvalid = w_dm_rvalid;
    assign bus.im_gnt    = w_im_gnt;
    assign bus.dm_gnt    = w_dm_gnt;
    assign bus.ld_gnt    = w_ld_gnt;
    assign bus.stall     = (bus.im_req & ~w_im_gnt) | (bus.dm_req & ~w_dm_gnt);

    assign bus.sram_w_en       = w_sram_w_en;
    assign bus.sram_address    = w_sram_addr;
    assign bus.sram_write_data = w_sram_wdata;
endmodule
